pampy_program_loader: RTL and testbench

Writer-side companion to the core's instruction fetch. The core only reads program memory, addressed by PC, one 16-bit word per instruction: the instruction byte in the upper half and the argument byte in the lower half. This block receives a byte-stream program image and writes it into that memory. It holds the core in reset while loading, then releases it and supervises the run until the finish signal or a cycle timeout.

---
 rtl/pampy_program_loader_pkg.sv | 30 +++
 rtl/pampy_program_loader_if.sv | 26 ++
 rtl/pampy_loader_run_timer.sv | 33 +++
 rtl/pampy_program_loader.sv | 156 +++++++++++++++
 tb/tb_pampy_program_loader.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pampy_program_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and error codes.
package pampy_program_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_INSTR,
    ST_ARG,
    ST_WRITE,
    ST_RUN,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_ZERO_LEN = 2'b01,
    ERR_TOO_LONG = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_t;

  localparam int CYCLE_COUNT_W = 32;

  // A (re)load request is only taken outside the loading sequence.
  function automatic logic start_honoured(input state_t s);
    return (s == ST_IDLE) || (s == ST_RUN) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/pampy_program_loader_if.sv
// Byte-stream input and program-memory write bus of the loader.
interface pampy_program_loader_if #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16
);

  logic [DATA_WIDTH-1:0]        BYTE_IN;
  logic                         BYTE_VALID;
  logic                         BYTE_READY;
  logic                         MEM_WE;
  logic [ADDR_WIDTH-1:0]        MEM_ADDR;
  logic [INSTRUCTION_WIDTH-1:0] MEM_DATA;

  // master: stream source and memory; slave: the loader itself
  modport master (
    output BYTE_IN, BYTE_VALID,
    input  BYTE_READY, MEM_WE, MEM_ADDR, MEM_DATA
  );

  modport slave (
    input  BYTE_IN, BYTE_VALID,
    output BYTE_READY, MEM_WE, MEM_ADDR, MEM_DATA
  );

endinterface

// File: rtl/pampy_loader_run_timer.sv
// Saturating run-cycle counter with timeout detection for the loader.
module pampy_loader_run_timer
  import pampy_program_loader_pkg::*;
#(
  parameter int MAX_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     en_i,
  output logic [CYCLE_COUNT_W-1:0] count_o,
  output logic                     timeout_o
);

  localparam logic [CYCLE_COUNT_W-1:0] LIMIT = CYCLE_COUNT_W'(MAX_CYCLES - 1);

  logic [CYCLE_COUNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != '1)) begin
      count_q <= count_q + CYCLE_COUNT_W'(1);
    end
  end

  // Asserted during the run cycle whose edge would complete MAX_CYCLES cycles.
  assign timeout_o = en_i && (count_q >= LIMIT);
  assign count_o   = count_q;

endmodule

// File: rtl/pampy_program_loader.sv
// Loads a length-prefixed byte-stream program into instruction memory,
// then releases the core and supervises its run until finish or timeout.
module pampy_program_loader
  import pampy_program_loader_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int MAX_CYCLES        = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       START,
  pampy_program_loader_if.slave      bus,
  output logic                       CORE_HOLD,
  input  logic                       FINISH_IN,
  output logic [ADDR_WIDTH:0]        LOADED_WORDS,
  output logic [CYCLE_COUNT_W-1:0]   CYCLE_COUNT,
  output logic                       DONE,
  output logic                       ERROR,
  output logic [1:0]                 ERR_CODE
);

  localparam int          LEN_W     = 2 * DATA_WIDTH;
  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  state_t                       state_q;
  err_code_t                    err_q;
  logic                         ready_q, we_q, hold_q, done_q, error_q;
  logic [ADDR_WIDTH-1:0]        addr_cnt_q, addr_cnt_d, mem_addr_q;
  logic [INSTRUCTION_WIDTH-1:0] mem_data_q;
  logic [ADDR_WIDTH:0]          loaded_q, loaded_d;
  logic [DATA_WIDTH-1:0]        len_hi_q, instr_q;
  logic [LEN_W-1:0]             len_q, len_d;
  logic                         accept, restart, timeout;
  logic [CYCLE_COUNT_W-1:0]     cycle_count;

  assign accept     = bus.BYTE_VALID && ready_q;
  assign restart    = START && start_honoured(state_q);
  assign len_d      = {len_hi_q, bus.BYTE_IN};
  assign addr_cnt_d = addr_cnt_q + ADDR_WIDTH'(1);
  assign loaded_d   = loaded_q + (ADDR_WIDTH + 1)'(1);

  pampy_loader_run_timer #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_run_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (restart),
    .en_i      (state_q == ST_RUN),
    .count_o   (cycle_count),
    .timeout_o (timeout)
  );

  // Stream byte capture; contents are only meaningful once captured.
  always_ff @(posedge clk) begin
    if (accept && (state_q == ST_LEN_HI)) len_hi_q <= bus.BYTE_IN;
    if (accept && (state_q == ST_LEN_LO)) len_q    <= len_d;
    if (accept && (state_q == ST_INSTR))  instr_q  <= bus.BYTE_IN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= ERR_NONE;
      addr_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      loaded_q   <= '0;
    end else if (restart) begin
      state_q    <= ST_LEN_HI;
      ready_q    <= 1'b1;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_q      <= ERR_NONE;
      addr_cnt_q <= '0;
      loaded_q   <= '0;
    end else begin
      case (state_q)
        ST_LEN_HI: if (accept) state_q <= ST_LEN_LO;
        ST_LEN_LO: begin
          if (accept) begin
            if (len_d == '0) begin
              state_q <= ST_ERROR;
              ready_q <= 1'b0;
              error_q <= 1'b1;
              err_q   <= ERR_ZERO_LEN;
            end else if (32'(len_d) > MAX_WORDS) begin
              state_q <= ST_ERROR;
              ready_q <= 1'b0;
              error_q <= 1'b1;
              err_q   <= ERR_TOO_LONG;
            end else begin
              state_q <= ST_INSTR;
            end
          end
        end
        ST_INSTR: if (accept) state_q <= ST_ARG;
        ST_ARG: begin
          if (accept) begin
            state_q    <= ST_WRITE;
            ready_q    <= 1'b0;
            we_q       <= 1'b1;
            mem_addr_q <= addr_cnt_q;
            mem_data_q <= {instr_q, bus.BYTE_IN};
          end
        end
        ST_WRITE: begin
          we_q       <= 1'b0;
          addr_cnt_q <= addr_cnt_d;
          loaded_q   <= loaded_d;
          if (32'(loaded_d) == 32'(len_q)) begin
            state_q <= ST_RUN;
            hold_q  <= 1'b0;
          end else begin
            state_q <= ST_INSTR;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          // Finish takes priority over a coincident timeout.
          if (FINISH_IN) begin
            state_q <= ST_DONE;
            hold_q  <= 1'b1;
            done_q  <= 1'b1;
          end else if (timeout) begin
            state_q <= ST_ERROR;
            hold_q  <= 1'b1;
            error_q <= 1'b1;
            err_q   <= ERR_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.BYTE_READY = ready_q;
  assign bus.MEM_WE     = we_q;
  assign bus.MEM_ADDR   = mem_addr_q;
  assign bus.MEM_DATA   = mem_data_q;
  assign CORE_HOLD      = hold_q;
  assign LOADED_WORDS   = loaded_q;
  assign CYCLE_COUNT    = cycle_count;
  assign DONE           = done_q;
  assign ERROR          = error_q;
  assign ERR_CODE       = err_q;

endmodule

// File: tb/tb_pampy_program_loader.sv
// Directed bench for pampy_program_loader with a write-logging memory model.
module tb_pampy_program_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        START;
  logic        FINISH_IN;
  logic        CORE_HOLD;
  logic [12:0] LOADED_WORDS;
  logic [31:0] CYCLE_COUNT;
  logic        DONE;
  logic        ERROR;
  logic [1:0]  ERR_CODE;

  int n_chk = 0;
  int n_bad = 0;

  pampy_program_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12), .INSTRUCTION_WIDTH(16)) bus ();

  pampy_program_loader #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .INSTRUCTION_WIDTH(16), .MAX_CYCLES(50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .START        (START),
    .bus          (bus),
    .CORE_HOLD    (CORE_HOLD),
    .FINISH_IN    (FINISH_IN),
    .LOADED_WORDS (LOADED_WORDS),
    .CYCLE_COUNT  (CYCLE_COUNT),
    .DONE         (DONE),
    .ERROR        (ERROR),
    .ERR_CODE     (ERR_CODE)
  );

  always #5 clk = ~clk;

  // Program memory model: captures each write strobe at the clock edge.
  logic [15:0] mem [0:4095];
  int          wr_n = 0;
  always @(posedge clk) begin
    if (bus.MEM_WE) begin
      mem[bus.MEM_ADDR] <= bus.MEM_DATA;
      wr_n <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.BYTE_IN    = b;
    bus.BYTE_VALID = 1'b1;
    while (!bus.BYTE_READY && n < 100) begin
      tick();
      n++;
    end
    if (!bus.BYTE_READY) check("byte_wait", {31'd0, bus.BYTE_READY}, 32'd1);
    tick();
    bus.BYTE_VALID = 1'b0;
  endtask

  task automatic send_len(input logic [15:0] n);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic send_word(input logic [7:0] ins, input logic [7:0] arg);
    send_byte(ins);
    send_byte(arg);
  endtask

  // Byte with random idle gaps; a START pulse is forced into each gap.
  task automatic send_byte_bp(input logic [7:0] b);
    int gap;
    gap = $urandom_range(1, 3);
    for (int g = 0; g < gap; g++) begin
      START = (g == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      tick();
      START = 1'b0;
    end
    send_byte(b);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int bad_words;
    logic [15:0] exp_w;
    logic [7:0]  bp_bytes [8];

    reset = 1'b1;
    START = 1'b0;
    FINISH_IN = 1'b0;
    bus.BYTE_IN = 8'h00;
    bus.BYTE_VALID = 1'b0;

    #2 reset = 1'b0;
    #1;
    check("rst_hold",   {31'd0, CORE_HOLD}, 32'd1);
    check("rst_ready",  {31'd0, bus.BYTE_READY}, 32'd0);
    check("rst_we",     {31'd0, bus.MEM_WE}, 32'd0);
    check("rst_loaded", {19'd0, LOADED_WORDS}, 32'd0);
    check("rst_cycles", CYCLE_COUNT, 32'd0);
    check("rst_done",   {31'd0, DONE}, 32'd0);
    check("rst_error",  {31'd0, ERROR}, 32'd0);
    check("rst_code",   {30'd0, ERR_CODE}, 32'd0);
    @(negedge clk) reset = 1'b1;
    tick();

    // Normal two-word load and finish after 10 run cycles
    base = wr_n;
    pulse_start();
    check("ready_len_hi", {31'd0, bus.BYTE_READY}, 32'd1);
    send_len(16'h0002);
    send_word(8'h11, 8'h05);
    check("w0_we",   {31'd0, bus.MEM_WE}, 32'd1);
    check("w0_addr", {20'd0, bus.MEM_ADDR}, 32'h000);
    check("w0_data", {16'd0, bus.MEM_DATA}, 32'h1105);
    send_word(8'h22, 8'h07);
    check("w1_addr", {20'd0, bus.MEM_ADDR}, 32'h001);
    check("w1_data", {16'd0, bus.MEM_DATA}, 32'h2207);
    check("w1_hold", {31'd0, CORE_HOLD}, 32'd1);
    tick();
    check("run_hold",   {31'd0, CORE_HOLD}, 32'd0);
    check("run_loaded", {19'd0, LOADED_WORDS}, 32'd2);
    check("run_we",     {31'd0, bus.MEM_WE}, 32'd0);
    check("n_writes",   wr_n - base, 32'd2);
    check("mem0",       {16'd0, mem[0]}, 32'h1105);
    check("mem1",       {16'd0, mem[1]}, 32'h2207);
    repeat (9) tick();
    FINISH_IN = 1'b1;
    tick();
    FINISH_IN = 1'b0;
    check("fin_done",   {31'd0, DONE}, 32'd1);
    check("fin_cycles", CYCLE_COUNT, 32'd10);
    check("fin_hold",   {31'd0, CORE_HOLD}, 32'd1);
    repeat (3) tick();
    check("done_sticky", {31'd0, DONE}, 32'd1);
    check("cyc_sticky",  CYCLE_COUNT, 32'd10);

    // Zero length
    base = wr_n;
    pulse_start();
    check("clr_done",   {31'd0, DONE}, 32'd0);
    check("clr_cycles", CYCLE_COUNT, 32'd0);
    check("clr_loaded", {19'd0, LOADED_WORDS}, 32'd0);
    send_len(16'h0000);
    check("zero_err",   {31'd0, ERROR}, 32'd1);
    check("zero_code",  {30'd0, ERR_CODE}, 32'd1);
    check("zero_hold",  {31'd0, CORE_HOLD}, 32'd1);
    check("zero_ready", {31'd0, bus.BYTE_READY}, 32'd0);
    tick();
    check("zero_nowr",  wr_n - base, 32'd0);

    // Oversize, then the largest legal image
    pulse_start();
    send_len(16'h1001);
    check("big_err",  {31'd0, ERROR}, 32'd1);
    check("big_code", {30'd0, ERR_CODE}, 32'd2);
    base = wr_n;
    pulse_start();
    send_len(16'h1000);
    for (int i = 0; i < 4096; i++) send_word(8'(i) ^ 8'h5A, 8'(i >> 4));
    check("full_last_addr", {20'd0, bus.MEM_ADDR}, 32'h0FFF);
    check("full_last_data", {16'd0, bus.MEM_DATA}, 32'hA5FF);
    tick();
    check("full_loaded", {19'd0, LOADED_WORDS}, 32'd4096);
    check("full_hold",   {31'd0, CORE_HOLD}, 32'd0);
    check("full_nwr",    wr_n - base, 32'd4096);
    bad_words = 0;
    for (int i = 0; i < 4096; i++) begin
      exp_w = {8'(i) ^ 8'h5A, 8'(i >> 4)};
      if (mem[i] !== exp_w) bad_words++;
    end
    check("full_mem", bad_words, 32'd0);

    // Timeout: no finish within 50 run cycles
    repeat (49) tick();
    check("to_early_err", {31'd0, ERROR}, 32'd0);
    check("to_early_cyc", CYCLE_COUNT, 32'd49);
    tick();
    check("to_err",   {31'd0, ERROR}, 32'd1);
    check("to_code",  {30'd0, ERR_CODE}, 32'd3);
    check("to_cyc",   CYCLE_COUNT, 32'd50);
    check("to_hold",  {31'd0, CORE_HOLD}, 32'd1);

    // Finish on the 50th run cycle beats the timeout
    pulse_start();
    send_len(16'h0001);
    send_word(8'hAB, 8'hCD);
    tick();
    repeat (49) tick();
    FINISH_IN = 1'b1;
    tick();
    FINISH_IN = 1'b0;
    check("tie_done", {31'd0, DONE}, 32'd1);
    check("tie_err",  {31'd0, ERROR}, 32'd0);
    check("tie_code", {30'd0, ERR_CODE}, 32'd0);
    check("tie_cyc",  CYCLE_COUNT, 32'd50);

    // Backpressure with START pulses during loading
    bp_bytes = '{8'h00, 8'h03, 8'h31, 8'h41, 8'h59, 8'h26, 8'h53, 8'h58};
    base = wr_n;
    pulse_start();
    foreach (bp_bytes[k]) send_byte_bp(bp_bytes[k]);
    tick();
    check("bp_nwr",    wr_n - base, 32'd3);
    check("bp_mem0",   {16'd0, mem[0]}, 32'h3141);
    check("bp_mem1",   {16'd0, mem[1]}, 32'h5926);
    check("bp_mem2",   {16'd0, mem[2]}, 32'h5358);
    check("bp_loaded", {19'd0, LOADED_WORDS}, 32'd3);
    check("bp_hold",   {31'd0, CORE_HOLD}, 32'd0);
    repeat (2) tick();
    pulse_start();
    check("rs_hold",   {31'd0, CORE_HOLD}, 32'd1);
    check("rs_ready",  {31'd0, bus.BYTE_READY}, 32'd1);
    check("rs_cycles", CYCLE_COUNT, 32'd0);

    // Asynchronous reset after the first write
    send_len(16'h0003);
    send_word(8'h12, 8'h34);
    tick();
    #2 reset = 1'b0;
    #1;
    check("ar_hold",   {31'd0, CORE_HOLD}, 32'd1);
    check("ar_ready",  {31'd0, bus.BYTE_READY}, 32'd0);
    check("ar_we",     {31'd0, bus.MEM_WE}, 32'd0);
    check("ar_addr",   {20'd0, bus.MEM_ADDR}, 32'd0);
    check("ar_data",   {16'd0, bus.MEM_DATA}, 32'd0);
    check("ar_loaded", {19'd0, LOADED_WORDS}, 32'd0);
    check("ar_mem0",   {16'd0, mem[0]}, 32'h1234);
    @(negedge clk) reset = 1'b1;
    tick();
    pulse_start();
    send_len(16'h0001);
    send_word(8'h56, 8'h78);
    check("rl_addr", {20'd0, bus.MEM_ADDR}, 32'd0);
    check("rl_data", {16'd0, bus.MEM_DATA}, 32'h5678);
    tick();
    check("rl_mem0",   {16'd0, mem[0]}, 32'h5678);
    check("rl_loaded", {19'd0, LOADED_WORDS}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
